sgd_x_from_memory_load: RTL
===========================

Name: sgd_x_from_memory_load

Overview:
- Loads the model vector x from host memory into the per-engine x-input FIFOs at the start of each epoch.
- Issues one memory read command per epoch, then accepts the 512-bit read-data stream.
- Distributes the data engine by engine: LINES_PER_ENGINE consecutive lines go to one engine, then the next engine, repeating per round.
- It is the read-side counterpart of the x write-back path; epoch k reads the model image that epoch k-1 wrote back.

Parameters:
- ENGINE_NUM, 8: number of SGD engines / x FIFOs.
- LINES_PER_ENGINE, 4: consecutive 512-bit lines per engine per round.
- FLOATS_PER_LINE, 16: 32-bit features per line.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- started  in  1  level; job parameters valid while high.
- addr_model  in  64  byte base address of the model image for epoch 0.
- dimension  in  32  number of features.
- numEpochs  in  32  number of epochs to load.
- epoch_load_req  in  1  pulse; engines are ready for the next epoch's x.
- x_load_cmd_valid  out  1  read command valid.
- x_load_cmd_ready  in  1  read command accepted.
- x_load_cmd_addr  out  64  byte address of the read.
- x_load_cmd_length  out  32  byte length of the read.
- x_load_data_in  in  512  read data.
- x_load_data_in_valid  in  1  read data valid.
- x_load_data_in_ready  out  1  module accepts data this cycle.
- x_from_mem_wr_data  out  ENGINE_NUM×512  per-FIFO write data.
- x_from_mem_wr_en  out  ENGINE_NUM  per-FIFO write enable.
- x_from_mem_almost_full  in  ENGINE_NUM  per-FIFO almost-full.
- x_load_epoch_done  out  1  one-cycle pulse; the last line of the epoch has been written.
- x_load_error  out  1  sticky; dimension==0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; all counters 0.
- started is double-registered (started_r2). Parameters are sampled on the started_r2 rising edge.
- Derived values:
  - ROUND = ENGINE_NUM*LINES_PER_ENGINE*FLOATS_PER_LINE (512 at defaults).
  - rounds = ceil(dimension/ROUND).
  - length = rounds*ROUND*4 bytes (32-bit, wraps silently).
  - lines/epoch = rounds*ENGINE_NUM*LINES_PER_ENGINE.
- State IDLE:
  - On started_r2 rise with dimension==0: set x_load_error and go to END.
  - On started_r2 rise otherwise: go to WAIT_REQ.
- State WAIT_REQ:
  - If epoch_idx==numEpochs: go to END.
  - Else if epoch_load_req: go to ISSUE.
  - epoch_load_req is ignored in all other states (no queuing).
- State ISSUE:
  - cmd_valid=1, cmd_addr = addr_model + epoch_idx*length (64-bit; computed as a running sum, no multiplier).
  - Hold valid, addr and length stable until cmd_ready. On the handshake cycle go to RECV.
- State RECV:
  - Counters inner (0..LINES_PER_ENGINE-1), engine (0..ENGINE_NUM-1), round (0..rounds-1).
  - data_in_ready = ~almost_full_r[engine], where almost_full_r is the 1-cycle-registered almost_full.
  - Beat = valid & ready. Each beat increments inner; inner wrap increments engine; engine wrap increments round.
  - The beat completing round==rounds-1, engine==ENGINE_NUM-1, inner==max goes to DONE.
- Write-side latency and FIFO slack:
  - A beat at cycle t produces wr_en[engine]=1 and wr_data[engine]=data at t+1 (registered). All other wr_en are 0.
  - wr_data of unselected engines is don't-care.
  - FIFOs assert almost_full with ≥3 free entries.
- State DONE:
  - Pulse x_load_epoch_done for 1 cycle, one cycle after the last wr_en.
  - epoch_idx++; go to WAIT_REQ.
- State END:
  - Remain in END until started_r2 falls, then go to IDLE. x_load_error clears on leaving END.
- data_in_ready is 0 outside RECV; excess data is not consumed.
- numEpochs==0: no command is issued; WAIT_REQ goes directly to END.
- started falling mid-epoch: the epoch completes (the memory read is already in flight). The FSM returns to IDLE only from END.
- Reset mid-operation: immediate return to IDLE; in-flight memory data is the system's responsibility.

Decomposition:
- Shared package sgd_pkg: ENGINE_NUM, LINES_PER_ENGINE, FLOATS_PER_LINE, ROUND constant, state enum typedef.
- One natural sub-module: sgd_line_distributor (inner/engine/round counters plus the registered per-engine write fan-out).
- The FSM, command path and address/length arithmetic stay in the top.

Test Plan:
- Single epoch: dimension=512, numEpochs=1, addr_model=0x1000, epoch_load_req once → one cmd addr=0x1000 len=2048; 32 beats; engine e receives exactly lines 4e..4e+3 in order; epoch_done pulse; END.
- Partial round: dimension=600 → rounds=2, len=4096, 64 lines delivered, engine 0 gets lines 0-3 and 32-35.
- Three epochs: dimension=1024, numEpochs=3 → cmd addrs base, base+4096, base+8192; each cmd issued only after a fresh epoch_load_req.
- Backpressure: hold almost_full[2]=1 for 20 cycles during engine 2's turn → data_in_ready=0 within 1 cycle of assertion; no data loss or duplication; no wr_en to other engines in the meantime.
- cmd_ready withheld for 10 cycles → addr and length stable throughout; exactly one command issued.
- dimension=0 → x_load_error=1, no cmd; async rst_n assertion mid-RECV → all outputs 0 immediately; after release, a new start behaves like a fresh job.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared constants and FSM state type for the x-from-memory load path.
// ROUND is assumed to be a power of two so the length arithmetic reduces to shifts.
package sgd_pkg;
    localparam int ENGINE_NUM       = 8;
    localparam int LINES_PER_ENGINE = 4;
    localparam int FLOATS_PER_LINE  = 16;
    localparam int LINE_W           = 512;
    localparam int ROUND            = ENGINE_NUM * LINES_PER_ENGINE * FLOATS_PER_LINE;
    localparam int ROUND_LOG2       = $clog2(ROUND);
    localparam int ROUNDS_W         = 33 - ROUND_LOG2;
    localparam int INNER_W          = $clog2(LINES_PER_ENGINE);
    localparam int ENG_W            = $clog2(ENGINE_NUM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_ISSUE,
        ST_RECV,
        ST_DONE,
        ST_END
    } state_t;
endpackage

// File: rtl/sgd_line_distributor.sv
// Walks the inner/engine/round counters over the read-data stream and fans each
// accepted line out to the owning engine's FIFO one cycle later.
module sgd_line_distributor
    import sgd_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_active,
    input  logic [ROUNDS_W-1:0]          i_rounds,
    input  logic [LINE_W-1:0]            i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic                         o_last_beat,
    input  logic [ENGINE_NUM-1:0]        i_almost_full,
    output logic [ENGINE_NUM*LINE_W-1:0] o_wr_data,
    output logic [ENGINE_NUM-1:0]        o_wr_en
);
    localparam logic [INNER_W-1:0] INNER_MAX = INNER_W'(LINES_PER_ENGINE - 1);
    localparam logic [ENG_W-1:0]   ENG_MAX   = ENG_W'(ENGINE_NUM - 1);

    logic [INNER_W-1:0]    r_inner;
    logic [ENG_W-1:0]      r_engine;
    logic [ROUNDS_W-1:0]   r_round;
    logic [ENGINE_NUM-1:0] r_af;
    logic                  w_beat;
    logic                  w_inner_wrap;
    logic                  w_engine_wrap;

    // almost_full is registered, so FIFOs must leave slack for the in-flight beat
    assign o_ready       = i_active & ~r_af[r_engine];
    assign w_beat        = i_valid & o_ready;
    assign w_inner_wrap  = (r_inner == INNER_MAX);
    assign w_engine_wrap = w_inner_wrap & (r_engine == ENG_MAX);
    assign o_last_beat   = w_beat & w_engine_wrap & ((r_round + ROUNDS_W'(1)) == i_rounds);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inner  <= '0;
            r_engine <= '0;
            r_round  <= '0;
            r_af     <= '0;
        end else begin
            r_af <= i_almost_full;
            if (w_beat) begin
                r_inner <= w_inner_wrap ? '0 : r_inner + INNER_W'(1);
                if (w_inner_wrap) begin
                    r_engine <= w_engine_wrap ? '0 : r_engine + ENG_W'(1);
                end
                if (w_engine_wrap) begin
                    r_round <= o_last_beat ? '0 : r_round + ROUNDS_W'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENGINE_NUM; gi++) begin : g_lane
            logic              w_sel;
            logic              r_en;
            logic [LINE_W-1:0] r_data;

            assign w_sel = w_beat & (r_engine == ENG_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_en   <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_en <= w_sel;
                    if (w_sel) begin
                        r_data <= i_data;
                    end
                end
            end

            assign o_wr_en[gi]                   = r_en;
            assign o_wr_data[gi*LINE_W +: LINE_W] = r_data;
        end
    endgenerate
endmodule

// File: rtl/sgd_x_from_memory_load.sv
// Per-epoch model-vector loader: one read command per epoch, then the line stream
// is distributed engine by engine into the x-input FIFOs.
module sgd_x_from_memory_load
    import sgd_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         started,
    input  logic [63:0]                  addr_model,
    input  logic [31:0]                  dimension,
    input  logic [31:0]                  numEpochs,
    input  logic                         epoch_load_req,
    output logic                         x_load_cmd_valid,
    input  logic                         x_load_cmd_ready,
    output logic [63:0]                  x_load_cmd_addr,
    output logic [31:0]                  x_load_cmd_length,
    input  logic [LINE_W-1:0]            x_load_data_in,
    input  logic                         x_load_data_in_valid,
    output logic                         x_load_data_in_ready,
    output logic [ENGINE_NUM*LINE_W-1:0] x_from_mem_wr_data,
    output logic [ENGINE_NUM-1:0]        x_from_mem_wr_en,
    input  logic [ENGINE_NUM-1:0]        x_from_mem_almost_full,
    output logic                         x_load_epoch_done,
    output logic                         x_load_error
);
    state_t              r_state;
    state_t              w_state_next;
    logic                r_started_1;
    logic                r_started_2;
    logic                r_started_3;
    logic                w_start_rise;
    logic [63:0]         r_cmd_addr;
    logic [31:0]         r_length;
    logic [31:0]         r_num_epochs;
    logic [31:0]         r_epoch_idx;
    logic [ROUNDS_W-1:0] r_rounds;
    logic                r_error;
    logic                r_epoch_done;
    logic [32:0]         w_dim_ceil;
    logic [ROUNDS_W-1:0] w_rounds;
    logic [31:0]         w_length;
    logic                w_cmd_valid;
    logic                w_recv;
    logic                w_last_beat;

    assign w_start_rise = r_started_2 & ~r_started_3;

    // rounds = ceil(dimension / ROUND); length = rounds * ROUND * 4 bytes, wrapping at 32 bits
    assign w_dim_ceil = {1'b0, dimension} + 33'(ROUND - 1);
    assign w_rounds   = ROUNDS_W'(w_dim_ceil >> ROUND_LOG2);
    assign w_length   = 32'({w_rounds, {(ROUND_LOG2 + 2){1'b0}}});

    always_comb begin
        w_state_next = r_state;
        w_cmd_valid  = 1'b0;
        w_recv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_next = (dimension == '0) ? ST_END : ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (r_epoch_idx == r_num_epochs) begin
                    w_state_next = ST_END;
                end else if (epoch_load_req) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cmd_valid = 1'b1;
                if (x_load_cmd_ready) begin
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                w_recv = 1'b1;
                if (w_last_beat) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_WAIT_REQ;
            ST_END: begin
                if (!r_started_2) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_started_1  <= 1'b0;
            r_started_2  <= 1'b0;
            r_started_3  <= 1'b0;
            r_cmd_addr   <= '0;
            r_length     <= '0;
            r_num_epochs <= '0;
            r_epoch_idx  <= '0;
            r_rounds     <= '0;
            r_error      <= 1'b0;
            r_epoch_done <= 1'b0;
        end else begin
            r_started_1  <= started;
            r_started_2  <= r_started_1;
            r_started_3  <= r_started_2;
            r_state      <= w_state_next;
            r_epoch_done <= (r_state == ST_DONE);
            if (r_state == ST_IDLE && w_start_rise) begin
                r_cmd_addr   <= addr_model;
                r_length     <= w_length;
                r_rounds     <= w_rounds;
                r_num_epochs <= numEpochs;
                r_epoch_idx  <= '0;
                r_error      <= (dimension == '0);
            end
            // running sum replaces epoch_idx * length
            if (r_state == ST_DONE) begin
                r_epoch_idx <= r_epoch_idx + 32'd1;
                r_cmd_addr  <= r_cmd_addr + {32'd0, r_length};
            end
            if (r_state == ST_END && !r_started_2) begin
                r_error <= 1'b0;
            end
        end
    end

    sgd_line_distributor u_dist (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_active      (w_recv),
        .i_rounds      (r_rounds),
        .i_data        (x_load_data_in),
        .i_valid       (x_load_data_in_valid),
        .o_ready       (x_load_data_in_ready),
        .o_last_beat   (w_last_beat),
        .i_almost_full (x_from_mem_almost_full),
        .o_wr_data     (x_from_mem_wr_data),
        .o_wr_en       (x_from_mem_wr_en)
    );

    assign x_load_cmd_valid  = w_cmd_valid;
    assign x_load_cmd_addr   = r_cmd_addr;
    assign x_load_cmd_length = r_length;
    assign x_load_epoch_done = r_epoch_done;
    assign x_load_error      = r_error;
endmodule
